ir_nec_rx: RTL and testbench

NEC-protocol infrared frame decoder between the IRDA_RXD board pin and the DW8051 SFR bus. It synchronises and de-glitches the raw demodulated IR line and measures low/high pulse widths in 1 µs units. It assembles 32-bit frames (LSB first), checks the key byte against its inverse, and holds the result with a valid flag until the CPU acknowledges it. It also flags NEC repeat codes, malformed frames and overruns.

---
 rtl/ir_nec_pkg.sv | 41 ++++
 rtl/ir_input_filter.sv | 50 +++++
 rtl/ir_nec_rx.sv | 200 ++++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and NEC pulse-width limits (in microseconds) for the IR frame decoder.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDR_LO,
        ST_LDR_HI,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_CHECK,
        ST_RPT_END
    } state_t;

    localparam int unsigned WIDTH_W = 14;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    localparam int unsigned LDR_LO_MIN = 8000;
    localparam int unsigned LDR_LO_MAX = 10000;
    localparam int unsigned LDR_HI_MIN = 4000;
    localparam int unsigned LDR_HI_MAX = 5000;
    localparam int unsigned RPT_HI_MIN = 2000;
    localparam int unsigned RPT_HI_MAX = 2500;
    localparam int unsigned BIT_LO_MIN = 300;
    localparam int unsigned BIT_LO_MAX = 800;
    localparam int unsigned B0_MIN     = 300;
    localparam int unsigned B0_MAX     = 800;
    localparam int unsigned B1_MIN     = 1400;
    localparam int unsigned B1_MAX     = 2000;

    // Limit in width-counter units; shift > 0 compresses all timing uniformly.
    function automatic logic [WIDTH_W-1:0] scale_us(input int unsigned us, input int unsigned shift);
        return WIDTH_W'(us >> shift);
    endfunction

    function automatic logic in_rng(input logic [WIDTH_W-1:0] w,
                                    input logic [WIDTH_W-1:0] lo,
                                    input logic [WIDTH_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Two-flop synchroniser plus N-sample glitch filter for the raw IR line.
// Edge strobes are asserted in the cycle before irf changes, so they align with the flip.
module ir_input_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic irf,
    output logic irf_rise,
    output logic irf_fall,
    output logic rx_high
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             flip_c;

    assign flip_c   = (sync2 != irf) && (cnt == CNT_W'(FILTER_LEN - 1));
    assign irf_rise = flip_c & sync2;
    assign irf_fall = flip_c & ~sync2;
    assign rx_high  = sync2;

    // Synchroniser resets low so a line held low through reset is not taken as idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            irf   <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != irf) begin
                if (flip_c) begin
                    irf <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder: pulse-width measurement, 32-bit frame assembly,
// key/inverse check and CPU handshake with repeat/error/overrun reporting.
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIME_SHIFT  = 0
) (
    input  logic        clk_50M,
    input  logic        reset_n,
    input  logic        ir_rxd,
    input  logic        rd_ack,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    output logic        frame_repeat,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [WIDTH_W-1:0] LL_MIN = scale_us(LDR_LO_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] LL_MAX = scale_us(LDR_LO_MAX, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] LH_MIN = scale_us(LDR_HI_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] LH_MAX = scale_us(LDR_HI_MAX, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] RH_MIN = scale_us(RPT_HI_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] RH_MAX = scale_us(RPT_HI_MAX, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] BL_MIN = scale_us(BIT_LO_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] BL_MAX = scale_us(BIT_LO_MAX, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] Z_MIN  = scale_us(B0_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] Z_MAX  = scale_us(B0_MAX, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] O_MIN  = scale_us(B1_MIN, TIME_SHIFT);
    localparam logic [WIDTH_W-1:0] O_MAX  = scale_us(B1_MAX, TIME_SHIFT);

    logic               irf;
    logic               irf_rise;
    logic               irf_fall;
    logic               rx_high;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [WIDTH_W-1:0] width;

    state_t      state, state_d;
    logic [4:0]  bit_idx, bit_idx_d;
    logic [31:0] shift, shift_d;
    logic [31:0] data_d;
    logic        valid_d, repeat_d, err_d, overrun_d;
    logic        armed, armed_d;

    ir_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk_50M),
        .rst_n    (reset_n),
        .raw      (ir_rxd),
        .irf      (irf),
        .irf_rise (irf_rise),
        .irf_fall (irf_fall),
        .rx_high  (rx_high)
    );

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    // Microsecond prescaler and saturating pulse-width counter, cleared on every edge.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            width   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (irf_rise || irf_fall) begin
                width <= '0;
            end else if (tick && (width != WIDTH_MAX)) begin
                width <= width + WIDTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bit_idx      <= '0;
            shift        <= '0;
            armed        <= 1'b0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            frame_repeat <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_d;
            bit_idx      <= bit_idx_d;
            shift        <= shift_d;
            armed        <= armed_d;
            frame_data   <= data_d;
            frame_valid  <= valid_d;
            frame_repeat <= repeat_d;
            frame_err    <= err_d;
            overrun      <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        data_d    = frame_data;
        valid_d   = frame_valid & ~rd_ack;
        overrun_d = overrun & ~rd_ack;
        repeat_d  = 1'b0;
        err_d     = 1'b0;
        // Frames are only accepted once the line has been seen idle-high.
        armed_d   = armed | (irf & rx_high);

        case (state)
            ST_IDLE: begin
                if (irf_fall && armed) state_d = ST_LDR_LO;
            end
            ST_LDR_LO: begin
                if (irf_rise) begin
                    if (in_rng(width, LL_MIN, LL_MAX)) begin
                        state_d = ST_LDR_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (width > LL_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LDR_HI: begin
                if (irf_fall) begin
                    if (in_rng(width, LH_MIN, LH_MAX)) begin
                        state_d   = ST_BIT_LO;
                        bit_idx_d = '0;
                    end else if (in_rng(width, RH_MIN, RH_MAX)) begin
                        state_d = ST_RPT_END;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (width > LH_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BIT_LO: begin
                if (irf_rise) begin
                    if (in_rng(width, BL_MIN, BL_MAX)) begin
                        state_d = ST_BIT_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (width > BL_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BIT_HI: begin
                if (irf_fall) begin
                    if (in_rng(width, Z_MIN, Z_MAX) || in_rng(width, O_MIN, O_MAX)) begin
                        shift_d   = {in_rng(width, O_MIN, O_MAX), shift[31:1]};
                        bit_idx_d = bit_idx + 5'd1;
                        state_d   = (bit_idx == 5'd31) ? ST_CHECK : ST_BIT_LO;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (width > O_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A load coinciding with rd_ack keeps valid set and is not an overrun.
                if (shift[23:16] == ~shift[31:24]) begin
                    data_d  = shift;
                    valid_d = 1'b1;
                    if (frame_valid && !rd_ack) overrun_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_RPT_END: begin
                if (irf_rise) begin
                    repeat_d = in_rng(width, BL_MIN, BL_MAX);
                    state_d  = ST_IDLE;
                end else if (width > BL_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx with all NEC timing compressed by 16 and one tick per clock.
module tb_ir_nec_rx;

    localparam int unsigned SHIFT = 4;

    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_rxd  = 1'b0;
    logic        rd_ack  = 1'b0;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_repeat;
    logic        frame_err;
    logic        overrun;

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    int rpt_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_data  = '0;
    logic        model_valid = 1'b0;
    logic        model_ovr   = 1'b0;

    always #10 clk_50M = ~clk_50M;

    ir_nec_rx #(
        .CLK_FREQ_HZ (1_000_000),
        .FILTER_LEN  (4),
        .TIME_SHIFT  (SHIFT)
    ) dut (
        .clk_50M      (clk_50M),
        .reset_n      (reset_n),
        .ir_rxd       (ir_rxd),
        .rd_ack       (rd_ack),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_repeat (frame_repeat),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    // Count every cycle a pulse output is high, so a stuck pulse shows up as a count > 1.
    always @(negedge clk_50M) begin
        if (frame_err === 1'b1)    err_cnt++;
        if (frame_repeat === 1'b1) rpt_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned cyc(input int unsigned us);
        return us >> SHIFT;
    endfunction

    task automatic hold(input logic lvl, input int unsigned us);
        ir_rxd = lvl;
        repeat (cyc(us)) @(negedge clk_50M);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, 560);
            if (w[i] && (i == glitch_bit)) begin
                ir_rxd = 1'b1;
                repeat (50) @(negedge clk_50M);
                ir_rxd = 1'b0;
                repeat (2) @(negedge clk_50M);
                ir_rxd = 1'b1;
                repeat (cyc(1690) - 52) @(negedge clk_50M);
            end else begin
                hold(1'b1, w[i] ? 1690 : 560);
            end
        end
    endtask

    task automatic ack();
        @(negedge clk_50M);
        rd_ack = 1'b1;
        @(negedge clk_50M);
        rd_ack = 1'b0;
        model_valid = 1'b0;
        model_ovr   = 1'b0;
        @(negedge clk_50M);
    endtask

    // Full frame; the load must land exactly 7 cycles after the stop-burst falling edge.
    task automatic send_frame(input logic [31:0] w, input logic good, input int glitch_bit);
        logic [31:0] exp;
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        send_bits(w, 32, glitch_bit);
        if (good) exp_q.push_back(w);
        ir_rxd = 1'b0;
        repeat (6) @(negedge clk_50M);
        chk("data_before_t7", frame_data, model_data);
        chk("valid_before_t7", 32'(frame_valid), 32'(model_valid));
        @(negedge clk_50M);
        if (good) begin
            exp = exp_q.pop_front();
            if (model_valid) model_ovr = 1'b1;
            model_valid = 1'b1;
            model_data  = exp;
            chk("frame_data", frame_data, exp);
            chk("valid_t7", 32'(frame_valid), 32'd1);
        end else begin
            chk("data_hold", frame_data, model_data);
            chk("valid_hold", 32'(frame_valid), 32'(model_valid));
        end
        hold(1'b0, 560);
        hold(1'b1, 2000);
    endtask

    initial begin
        reset_n = 1'b0;
        ir_rxd  = 1'b0;
        repeat (5) @(negedge clk_50M);
        chk("rst_data", frame_data, 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_repeat", 32'(frame_repeat), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Line low out of reset, then a lone 1 ms low pulse.
        reset_n = 1'b1;
        hold(1'b0, 1000);
        hold(1'b1, 20000);
        hold(1'b0, 1000);
        hold(1'b1, 3000);
        chk("noise_err_cnt", 32'(err_cnt), 32'd1);
        chk("noise_valid", 32'(frame_valid), 32'd0);
        chk("noise_data", frame_data, 32'h0);

        send_frame(32'hA956_3412, 1'b1, -1);
        chk("a_overrun", 32'(overrun), 32'd0);
        chk("a_err_cnt", 32'(err_cnt), 32'd1);
        ack();
        chk("a_ack_valid", 32'(frame_valid), 32'd0);

        send_frame(32'hA956_3412, 1'b1, -1);
        send_frame(32'h0FF0_B668, 1'b1, -1);
        chk("b_overrun", 32'(overrun), 32'(model_ovr));
        chk("b_overrun_set", 32'(overrun), 32'd1);
        ack();
        chk("b_ack_valid", 32'(frame_valid), 32'd0);
        chk("b_ack_overrun", 32'(overrun), 32'd0);

        send_frame(32'h5756_3412, 1'b0, -1);
        chk("bad_err_cnt", 32'(err_cnt), 32'd2);
        chk("bad_data", frame_data, 32'h0FF0_B668);

        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 2000);
        chk("rpt_cnt", 32'(rpt_cnt), 32'd1);
        chk("rpt_err_cnt", 32'(err_cnt), 32'd2);
        chk("rpt_valid", 32'(frame_valid), 32'd0);

        send_frame(32'hE11E_FF00, 1'b1, 8);
        chk("glitch_err_cnt", 32'(err_cnt), 32'd2);

        // Abort mid-frame at bit 15 with reset.
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        send_bits(32'h0000_5A5A, 15, -1);
        ir_rxd = 1'b0;
        repeat (10) @(negedge clk_50M);
        reset_n = 1'b0;
        ir_rxd  = 1'b1;
        repeat (3) @(negedge clk_50M);
        chk("mid_rst_data", frame_data, 32'h0);
        chk("mid_rst_valid", 32'(frame_valid), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_err", 32'(frame_err), 32'd0);
        chk("mid_rst_repeat", 32'(frame_repeat), 32'd0);
        model_data  = '0;
        model_valid = 1'b0;
        model_ovr   = 1'b0;
        reset_n = 1'b1;
        repeat (20) @(negedge clk_50M);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd2);

        send_frame(32'h7F80_0104, 1'b1, -1);
        chk("post_rst_overrun", 32'(overrun), 32'd0);
        chk("final_err_cnt", 32'(err_cnt), 32'd2);
        chk("final_rpt_cnt", 32'(rpt_cnt), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
